// File: rtl/regfile_arbiter_if.sv
// Bus bundle between the two requesters, the register-file arbiter and the register file.
// The slave modport is the arbiter's view; the master modport is the requester/register-file side.
interface regfile_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr_a0;
    logic [ADDR_W-1:0] addr_b0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr_a1;
    logic [ADDR_W-1:0] addr_b1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rsp_valid;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;
    logic [ADDR_W-1:0] rf_address_a;
    logic [ADDR_W-1:0] rf_address_b;
    logic              rf_write_enable;
    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;

    modport slave (
        input  req0, we0, addr_a0, addr_b0, wdata0,
        input  req1, we1, addr_a1, addr_b1, wdata1,
        output gnt0, gnt1,
        output rsp_valid, rsp_id, rsp_data_a, rsp_data_b,
        output rf_address_a, rf_address_b, rf_write_enable, rf_write_data,
        input  rf_data_a, rf_data_b
    );

    modport master (
        output req0, we0, addr_a0, addr_b0, wdata0,
        output req1, we1, addr_a1, addr_b1, wdata1,
        input  gnt0, gnt1,
        input  rsp_valid, rsp_id, rsp_data_a, rsp_data_b,
        input  rf_address_a, rf_address_b, rf_write_enable, rf_write_data,
        output rf_data_a, rf_data_b
    );
endinterface

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between two requesters, one op in flight.
// Optional REGFILE_ARB_R0ZERO_EN makes register 0 read as zero and ignore writes.
module regfile_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_arbiter_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cmd_we_q, cmd_we_d;
    logic              cmd_id_q, cmd_id_d;
    logic [ADDR_W-1:0] cmd_addr_a_q, cmd_addr_a_d;
    logic [ADDR_W-1:0] cmd_addr_b_q, cmd_addr_b_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

    logic              wr_allowed;
    logic              zero_a;
    logic              zero_b;

`ifdef REGFILE_ARB_R0ZERO_EN
    assign wr_allowed = (cmd_addr_a_q != '0);
    assign zero_a     = (cmd_addr_a_q == '0);
    assign zero_b     = (cmd_addr_b_q == '0);
`else
    assign wr_allowed = 1'b1;
    assign zero_a     = 1'b0;
    assign zero_b     = 1'b0;
`endif

    // Address and write data come straight from the command register, so they hold between ops.
    assign bus.rf_address_a  = cmd_addr_a_q;
    assign bus.rf_address_b  = cmd_addr_b_q;
    assign bus.rf_write_data = cmd_wdata_q;

    always_comb begin
        logic win;
        win                 = 1'b0;
        state_d             = state_q;
        last_grant_d        = last_grant_q;
        cmd_we_d            = cmd_we_q;
        cmd_id_d            = cmd_id_q;
        cmd_addr_a_d        = cmd_addr_a_q;
        cmd_addr_b_d        = cmd_addr_b_q;
        cmd_wdata_d         = cmd_wdata_q;
        bus.gnt0            = 1'b0;
        bus.gnt1            = 1'b0;
        bus.rsp_valid       = 1'b0;
        bus.rsp_id          = 1'b0;
        bus.rsp_data_a      = '0;
        bus.rsp_data_b      = '0;
        bus.rf_write_enable = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rst && (bus.req0 || bus.req1)) begin
                    // On a tie the requester not granted last wins.
                    win          = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
                    bus.gnt0     = ~win;
                    bus.gnt1     = win;
                    last_grant_d = win;
                    cmd_id_d     = win;
                    cmd_we_d     = win ? bus.we1     : bus.we0;
                    cmd_addr_a_d = win ? bus.addr_a1 : bus.addr_a0;
                    cmd_addr_b_d = win ? bus.addr_b1 : bus.addr_b0;
                    cmd_wdata_d  = win ? bus.wdata1  : bus.wdata0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                bus.rf_write_enable = cmd_we_q & ~rst & wr_allowed;
                state_d             = RESP;
            end
            RESP: begin
                if (!rst) begin
                    bus.rsp_valid  = 1'b1;
                    bus.rsp_id     = cmd_id_q;
                    bus.rsp_data_a = zero_a ? '0 : bus.rf_data_a;
                    bus.rsp_data_b = zero_b ? '0 : bus.rf_data_b;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cmd_we_q     <= 1'b0;
            cmd_id_q     <= 1'b0;
            cmd_addr_a_q <= '0;
            cmd_addr_b_q <= '0;
            cmd_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_we_q     <= cmd_we_d;
            cmd_id_q     <= cmd_id_d;
            cmd_addr_a_q <= cmd_addr_a_d;
            cmd_addr_b_q <= cmd_addr_b_d;
            cmd_wdata_q  <= cmd_wdata_d;
        end
    end
endmodule

// File: doc/regfile_arbiter.md
Name: regfile_arbiter

Overview:
- Shares the single 16-bit x 8-entry register file between two requesters: requester 0 is the execute stage and requester 1 is the load/debug unit.
- Each access is accepted through a req/gnt handshake.
- The arbiter sequences the register file's write port (shared address_a) and its 1-cycle registered reads, then returns both read words with a response strobe.
- Arbitration is round-robin; there is one operation in flight at a time.

Parameters:
DATA_W, 16, register word width
ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req0  in  1  requester 0 request; held until gnt0
we0  in  1  requester 0 op: 1 = write wdata0 to addr_a0, 0 = read
addr_a0  in  ADDR_W  requester 0 port-A / write address
addr_b0  in  ADDR_W  requester 0 port-B address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 grant, 1-cycle pulse
req1, we1, addr_a1, addr_b1, wdata1, gnt1  (same as above, requester 1)
rsp_valid  out  1  response strobe, 1 cycle
rsp_id  out  1  requester that owns the response
rsp_data_a  out  DATA_W  register file data_a for the op
rsp_data_b  out  DATA_W  register file data_b for the op
rf_address_a  out  ADDR_W  to register file address_a
rf_address_b  out  ADDR_W  to register file address_b
rf_write_enable  out  1  to register file write_enable
rf_write_data  out  DATA_W  to register file write_data
rf_data_a  in  DATA_W  from register file data_a (registered, 1-cycle latency)
rf_data_b  in  DATA_W  from register file data_b

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, grant one: gntN=1 combinationally in that cycle.
  - Latch we/addr_a/addr_b/wdata of the winner, plus its id, into a command register.
  - Next state is ISSUE.
- ISSUE:
  - rf_address_a/b and rf_write_data are driven from the command register.
  - rf_write_enable = cmd_we & ~rst.
  - Next state is RESP.
- RESP:
  - rsp_valid=1, rsp_id=cmd_id, rsp_data_a/b = rf_data_a/b.
  - This happens for both reads and writes. For a write, rsp_data_a equals the written word.
  - Next state is IDLE.
- Latency and throughput: gnt in cycle N, rsp_valid in cycle N+2, next gnt no earlier than N+3. Max throughput is 1 op per 3 cycles.
- gnt0/gnt1 are asserted only in IDLE and are never both high.
- Arbitration:
  - A single request wins immediately.
  - When both requests are high, the winner is the requester that was not granted last.
  - last_grant updates on every grant and resets to 1, so requester 0 wins the first tie.
- Requesters must hold req and its fields stable until gnt. The arbiter ignores request field changes after the grant edge.
- When no op is in progress (IDLE, RESP), rf_write_enable=0. Address outputs hold their last command values.
- Reset values: state=IDLE, gnt0/gnt1=0 (no grant while rst), rsp_valid=0, rsp_id=0, rsp_data_a/b=0 (gated to 0 when not valid), rf_write_enable=0, rf_address_a/b=0, rf_write_data=0, command register=0, last_grant=1.
- Reset mid-operation:
  - rst in ISSUE suppresses the write.
  - rst in RESP suppresses rsp_valid.
  - The in-flight op is dropped without a response. The requester must re-request.
- Simultaneous req and rsp: a new request arriving while in RESP is not granted until the following IDLE cycle.

Optional Feature:
- Macro: REGFILE_ARB_R0ZERO_EN.
- When defined, register 0 is hard-wired to zero:
  - A write with cmd addr_a=0 keeps rf_write_enable=0 in ISSUE but still produces a response.
  - rsp_data_a is forced to 0 when cmd addr_a=0; rsp_data_b is forced to 0 when cmd addr_b=0.
- When undefined, register 0 behaves like every other register.

Test Plan:
- Write then read: req0 we0=1 addr_a0=5 wdata0=16'hBEEF, then read addr_a0=5 addr_b0=2 (reg2 previously written 16'h1234) -> gnt0 pulse; rf_write_enable=1 for exactly one cycle; rsp_valid at +2 with rsp_id=0, rsp_data_a=16'hBEEF, rsp_data_b=16'h1234.
- Tie after reset: req0=req1=1 held continuously -> grants alternate 0,1,0,1, spaced 3 cycles apart; rsp_id sequence 0,1,0,1.
- Single requester streaming: req1 only, 4 reads -> gnt1 every 3 cycles; gnt0 never asserted; 4 responses with rsp_id=1.
- Reset in ISSUE of a write of 16'hAAAA to reg 3 -> no write reaches the register file; no rsp_valid; a subsequent read of reg 3 returns its prior value.
- With REGFILE_ARB_R0ZERO_EN: write 16'hFFFF to reg 0, then read addr_a=0 addr_b=0 -> rf_write_enable stays 0; write response rsp_valid=1; read response rsp_data_a=rsp_data_b=0.
- Late request: req1 rises during RESP of a requester-0 op -> gnt1 in the next IDLE cycle, not during RESP.
